// File: rtl/sprite_draw_engine.sv
// Rectangular sprite plotter: latches an origin/colour on start, then sweeps a
// SPRITE_W x SPRITE_H box one pixel per clock with clipping against the screen.
module sprite_draw_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  input  logic [CW-1:0] colour_in,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          plot
);

  localparam logic [XW-1:0] C_LAST  = XW'(SPRITE_W - 1);
  localparam logic [YW-1:0] R_LAST  = YW'(SPRITE_H - 1);
  localparam logic [XW:0]   X_LIMIT = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]   Y_LIMIT = (YW+1)'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [XW-1:0] r_x0, r_prev_x, r_c;
  logic [YW-1:0] r_y0, r_prev_y, r_r;
  logic [CW-1:0] r_col, r_prev_col;
  logic [XW:0]   w_x_sum;
  logic [YW:0]   w_y_sum;
  logic          w_last;
  logic          w_visible;

  // One extra bit on the sums so an origin near the top of the range clips
  // instead of wrapping back onto the screen.
  assign w_x_sum   = {1'b0, r_x0} + {1'b0, r_c};
  assign w_y_sum   = {1'b0, r_y0} + {1'b0, r_r};
  assign w_visible = (w_x_sum < X_LIMIT) && (w_y_sum < Y_LIMIT);
  assign w_last    = (r_c == C_LAST) && (r_r == R_LAST);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_DRAW;
      S_DRAW:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_x0       <= '0;
      r_y0       <= '0;
      r_col      <= '0;
      r_prev_x   <= '0;
      r_prev_y   <= '0;
      r_prev_col <= '0;
      r_c        <= '0;
      r_r        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      plot <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_c <= '0;
            r_r <= '0;
            case (mode)
              2'b00: begin
                r_x0       <= x_in;
                r_y0       <= y_in;
                r_col      <= colour_in;
                r_prev_x   <= x_in;
                r_prev_y   <= y_in;
                r_prev_col <= colour_in;
              end
              2'b01: begin
                r_x0  <= x_in;
                r_y0  <= y_in;
                r_col <= '1;
              end
              2'b10: begin
                r_x0  <= r_prev_x;
                r_y0  <= r_prev_y;
                r_col <= r_prev_col;
              end
              default: begin
                r_x0  <= r_prev_x;
                r_y0  <= r_prev_y;
                r_col <= '0;
              end
            endcase
          end
        end
        S_DRAW: begin
          x_out      <= w_x_sum[XW-1:0];
          y_out      <= w_y_sum[YW-1:0];
          colour_out <= r_col;
          plot       <= w_visible;
          busy       <= 1'b1;
          // Row is the inner loop: it wraps and bumps the column.
          if (r_r == R_LAST) begin
            r_r <= '0;
            r_c <= r_c + 1'b1;
          end else begin
            r_r <= r_r + 1'b1;
          end
        end
        S_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Bench for sprite_draw_engine: a queue-based pixel model checked every cycle,
// plus hand-computed expectations for each directed draw.
module tb_sprite_draw_engine;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  int n_total = 0;
  int n_pass  = 0;

  sprite_draw_engine dut (
    .clock(clock), .resetn(resetn), .start(start), .mode(mode),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int x; int y; int col; bit p;} pix_t;
  pix_t q[$];
  bit   m_active = 0, m_finish = 0;
  int   m_px = 0, m_py = 0, m_pc = 0;
  bit   m_busy = 0, m_done = 0, m_plot = 0;
  int   m_x = 0, m_y = 0, m_col = 0;
  bit   chk_en = 0;

  always @(posedge clock) begin
    if (!resetn) begin
      q.delete();
      m_active = 0; m_finish = 0;
      m_px = 0; m_py = 0; m_pc = 0;
      m_busy = 0; m_done = 0; m_plot = 0;
      m_x = 0; m_y = 0; m_col = 0;
      chk_en = 1;
    end else if (m_active) begin
      pix_t p;
      p = q.pop_front();
      m_x = p.x; m_y = p.y; m_col = p.col; m_plot = p.p;
      m_busy = 1; m_done = 0;
      if (q.size() == 0) begin
        m_active = 0;
        m_finish = 1;
      end
    end else if (m_finish) begin
      m_finish = 0;
      m_busy = 0; m_plot = 0; m_done = 1;
    end else begin
      m_busy = 0; m_plot = 0; m_done = 0;
      if (start) begin
        int ox, oy, oc;
        case (mode)
          2'b00: begin ox = x_in; oy = y_in; oc = colour_in;
                       m_px = ox; m_py = oy; m_pc = oc; end
          2'b01: begin ox = x_in; oy = y_in; oc = 7; end
          2'b10: begin ox = m_px; oy = m_py; oc = m_pc; end
          default: begin ox = m_px; oy = m_py; oc = 0; end
        endcase
        for (int c = 0; c < 8; c++)
          for (int r = 0; r < 8; r++) begin
            pix_t p;
            p.x = (ox + c) % 256;
            p.y = (oy + r) % 128;
            p.col = oc;
            p.p = ((ox + c) < 160) && ((oy + r) < 120);
            q.push_back(p);
          end
        m_active = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      logic [20:0] act, exp;
      act = {busy, done, plot, x_out, y_out, colour_out};
      exp = {m_busy, m_done, m_plot, 8'(m_x), 7'(m_y), 3'(m_col)};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL cycle_model t=%0t: got {busy,done,plot,x,y,col}=%h expected %h",
                    $time, act, exp);
    end
  end

  // ---------------- directed stimulus ----------------
  int res_cyc, res_plot, res_busy, res_fx, res_fy, res_fc, res_lx, res_ly, res_done;

  task automatic run_draw(input logic [1:0] md, input int xi, input int yi, input int ci,
                          input int glitch_at, input int abort_at);
    int cyc;
    bit fin;
    @(negedge clock);
    mode = md; x_in = 8'(xi); y_in = 7'(yi); colour_in = 3'(ci);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 0; fin = 0;
    res_plot = 0; res_busy = 0; res_done = 0;
    res_fx = -1; res_fy = -1; res_fc = -1; res_lx = -1; res_ly = -1;
    while (!fin && cyc < 200) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (plot) begin
        res_plot++;
        if (res_fx < 0) begin res_fx = x_out; res_fy = y_out; res_fc = colour_out; end
        res_lx = x_out; res_ly = y_out;
      end
      if (busy) res_busy++;
      if (done) begin res_done++; fin = 1; end
      if (cyc == glitch_at) begin
        start = 1'b1; mode = 2'b01; x_in = 8'd0; y_in = 7'd0;
      end
      if (cyc == abort_at) begin
        resetn = 1'b0;
        @(negedge clock);
        chk("abort_plot", int'(plot), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_xy", int'({x_out, y_out, colour_out}), 0);
        resetn = 1'b1;
        fin = 1;
      end
    end
    res_cyc = cyc;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_outputs", int'({busy, done, plot, x_out, y_out, colour_out}), 0);
    resetn = 1'b1;

    run_draw(2'b00, 10, 20, 5, -1, -1);
    chk("m00_done_cycle", res_cyc, 65);
    chk("m00_plots", res_plot, 64);
    chk("m00_busy_cycles", res_busy, 64);
    chk("m00_first_x", res_fx, 10);
    chk("m00_first_y", res_fy, 20);
    chk("m00_colour", res_fc, 5);
    chk("m00_last_x", res_lx, 17);
    chk("m00_last_y", res_ly, 27);

    run_draw(2'b01, 0, 0, 2, -1, -1);
    chk("m01_plots", res_plot, 64);
    chk("m01_colour", res_fc, 7);
    chk("m01_first_xy", res_fx * 1000 + res_fy, 0);

    run_draw(2'b10, 99, 99, 0, -1, -1);
    chk("m10_first_xy", res_fx * 1000 + res_fy, 10020);
    chk("m10_colour", res_fc, 5);

    run_draw(2'b11, 99, 99, 6, -1, -1);
    chk("m11_plots", res_plot, 64);
    chk("m11_colour", res_fc, 0);
    chk("m11_first_xy", res_fx * 1000 + res_fy, 10020);

    run_draw(2'b10, 0, 0, 0, -1, -1);
    chk("prev_kept_xy", res_fx * 1000 + res_fy, 10020);
    chk("prev_kept_col", res_fc, 5);

    run_draw(2'b00, 156, 116, 3, -1, -1);
    chk("clip_plots", res_plot, 16);
    chk("clip_done_cycle", res_cyc, 65);
    chk("clip_first", res_fx * 1000 + res_fy, 156116);
    chk("clip_last", res_lx * 1000 + res_ly, 159119);

    run_draw(2'b00, 255, 0, 1, -1, -1);
    chk("nowrap_plots", res_plot, 0);
    chk("nowrap_done_cycle", res_cyc, 65);

    run_draw(2'b00, 10, 20, 5, 10, -1);
    chk("glitch_plots", res_plot, 64);
    chk("glitch_done_cycle", res_cyc, 65);
    chk("glitch_last", res_lx * 1000 + res_ly, 17027);

    run_draw(2'b00, 30, 40, 2, -1, 30);
    chk("abort_no_done", res_done, 0);
    chk("abort_plots", res_plot, 30);

    run_draw(2'b00, 30, 40, 2, -1, -1);
    chk("fresh_plots", res_plot, 64);
    chk("fresh_done_cycle", res_cyc, 65);
    chk("fresh_last", res_lx * 1000 + res_ly, 37047);

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
